mem_bus_responder: RTL and testbench

//  Responder end of the CPU data-memory request interface. It accepts one load or store
//  per valid/ready handshake and holds it for a fixed number of wait states.
//  It then performs the access on an internal word array and returns data or error

---
 rtl/mem_bus_responder.sv | 194 +++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Data-memory responder: one valid/ready request, WAIT_CYCLES wait states, then access and response.
// Optional MEM_BUS_RESP_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module mem_bus_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;

    logic               cap_we;
    logic [1:0]         cap_size;
    logic               cap_unsigned;
    logic [ADDR_W-1:0]  cap_addr;
    logic [31:0]        cap_wdata;

    logic               a_we;
    logic [1:0]         a_size;
    logic               a_unsigned;
    logic [ADDR_W-1:0]  a_addr;
    logic [31:0]        a_wdata;

    logic               access;
    logic               acc_err;
    logic               mem_we;
    logic [1:0]         lane_off;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         byte_en;
    logic [31:0]        lane_wdata;
    logic [31:0]        shifted;
    logic [31:0]        load_ext;

    logic [31:0]        mem [DEPTH];

    assign req_ready = (state == S_IDLE) && !rst_in;

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        a_we       = cap_we;
        a_size     = cap_size;
        a_unsigned = cap_unsigned;
        a_addr     = cap_addr;
        a_wdata    = cap_wdata;
        if (state == S_IDLE) begin
            a_we       = req_we;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
        end

        access = !rst_in &&
                 (((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (wait_cnt == CNT_LAST)));

`ifdef MEM_BUS_RESP_MISALIGN_TRAP_EN
        acc_err = (a_size == SZ_RSVD) ||
                  ((a_size == SZ_HALF) && a_addr[0]) ||
                  ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
`else
        acc_err = (a_size == SZ_RSVD);
`endif

        // Misaligned halves/words are force-aligned; with the trap enabled they never reach the array.
        case (a_size)
            SZ_HALF: lane_off = {a_addr[1], 1'b0};
            SZ_WORD: lane_off = 2'b00;
            default: lane_off = a_addr[1:0];
        endcase

        idx = IDX_W'((a_addr >> 2) % ADDR_W'(DEPTH));

        case (a_size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << lane_off;
                lane_wdata = {4{a_wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = 4'b0011 << lane_off;
                lane_wdata = {2{a_wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                lane_wdata = a_wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                lane_wdata = a_wdata;
            end
        endcase

        shifted = mem[idx] >> {lane_off, 3'b000};

        case (a_size)
            SZ_BYTE: load_ext = a_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = a_unsigned ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase

        mem_we = access && a_we && !acc_err;
    end

    // NOTE: the word array has no reset; contents survive rst_in and it maps onto plain RAM.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        wait_cnt     <= '0;
                        state        <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Response fields are loaded once on entry to RESP and then held until the handshake.
            if (access) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (a_we || acc_err) ? 32'h0 : load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (default parameters, WAIT_CYCLES=2).
// Expectations for the misaligned word store follow MEM_BUS_RESP_MISALIGN_TRAP_EN.
module tb_mem_bus_responder;

    localparam int WAIT_CYCLES = 2;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    mem_bus_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full request/response; latency counts negedges after the accept edge until resp_valid.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cycles);
        int n;
        @(negedge clk_in);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
        @(posedge clk_in);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wdata;
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!resp_valid && cycles < 20);
        if (!resp_valid) check("resp_timeout", 32'(cycles), 32'(WAIT_CYCLES + 1));
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk_in);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;

        // Reset state
        @(posedge clk_in);
        @(negedge clk_in);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        rst_in = 1'b0;
        #1;
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Word store/load with latency
        xact(1'b1, SZ_W, 1'b0, 32'h68, 32'hDEADBEEF, rd, er, lat);
        check("sw_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        check("sw_err", {31'h0, er}, 32'h0);
        check("sw_rdata", rd, 32'h0);
        xact(1'b0, SZ_W, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("lw_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        check("lw_68", rd, 32'hDEADBEEF);

        // Sub-word loads and extension
        xact(1'b0, SZ_B, 1'b0, 32'h69, 32'h0, rd, er, lat);
        check("lb_69", rd, 32'hFFFFFFBE);
        xact(1'b0, SZ_B, 1'b1, 32'h69, 32'h0, rd, er, lat);
        check("lbu_69", rd, 32'h000000BE);
        xact(1'b0, SZ_H, 1'b0, 32'h6A, 32'h0, rd, er, lat);
        check("lh_6a", rd, 32'hFFFFDEAD);
        xact(1'b0, SZ_H, 1'b1, 32'h6A, 32'h0, rd, er, lat);
        check("lhu_6a", rd, 32'h0000DEAD);
        xact(1'b0, SZ_B, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("lb_68", rd, 32'hFFFFFFEF);

        // Byte store into top lane, then reserved size
        xact(1'b1, SZ_B, 1'b0, 32'h6B, 32'hAAAAAA11, rd, er, lat);
        check("sb_err", {31'h0, er}, 32'h0);
        xact(1'b0, SZ_W, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("lw_after_sb", rd, 32'h11ADBEEF);
        xact(1'b1, SZ_R, 1'b0, 32'h68, 32'h12345678, rd, er, lat);
        check("rsvd_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        check("rsvd_err", {31'h0, er}, 32'h1);
        check("rsvd_rdata", rd, 32'h0);
        xact(1'b0, SZ_W, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("lw_after_rsvd", rd, 32'h11ADBEEF);

        // Response stall with requests pulsed while busy
        xact(1'b1, SZ_W, 1'b0, 32'h20, 32'h01020304, rd, er, lat);
        @(negedge clk_in);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h68;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555;
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!resp_valid && lat < 20);
        check("stall_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            @(negedge clk_in);
            check("stall_valid", {31'h0, resp_valid}, 32'h1);
            check("stall_rdata", resp_rdata, 32'h11ADBEEF);
            check("stall_err", {31'h0, resp_err}, 32'h0);
            check("stall_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk_in);
        #1;
        resp_ready = 1'b0;
        @(negedge clk_in);
        check("after_hs_valid", {31'h0, resp_valid}, 32'h0);
        check("after_hs_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("no_extra_resp", {31'h0, resp_valid}, 32'h0);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("extra_not_written", rd, 32'h01020304);

        // Misaligned word store
        xact(1'b1, SZ_W, 1'b0, 32'h6A, 32'hCAFEF00D, rd, er, lat);
`ifdef MEM_BUS_RESP_MISALIGN_TRAP_EN
        check("misal_err", {31'h0, er}, 32'h1);
        xact(1'b0, SZ_W, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("misal_unchanged", rd, 32'h11ADBEEF);
`else
        check("misal_err", {31'h0, er}, 32'h0);
        xact(1'b0, SZ_W, 1'b0, 32'h68, 32'h0, rd, er, lat);
        check("misal_aligned", rd, 32'hCAFEF00D);
`endif

        // Reset during WAIT drops the store
        xact(1'b1, SZ_W, 1'b0, 32'h10, 32'hA5A5A5A5, rd, er, lat);
        @(negedge clk_in);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h10; req_wdata = 32'h77777777;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("rst_wait_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("rst_release_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("rst_no_write", rd, 32'hA5A5A5A5);

        // Address wrap modulo DEPTH
        xact(1'b1, SZ_W, 1'b0, 32'h100, 32'h13579BDF, rd, er, lat);
        check("wrap_err", {31'h0, er}, 32'h0);
        xact(1'b0, SZ_W, 1'b0, 32'h000, 32'h0, rd, er, lat);
        check("wrap_load_0", rd, 32'h13579BDF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
